// File: rtl/difftest_step_pkg.sv
// Shared types and sizing helpers for the difftest step scheduler.
package difftest_step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } sched_state_e;

  localparam int unsigned DEF_NUM_CORES = 2;
  localparam int unsigned DEF_STEP_W    = 8;

  // Width of the lane sum: one extra bit per doubling of the lane count.
  function automatic int unsigned sum_width(input int unsigned step_w,
                                            input int unsigned num_cores);
    return step_w + $clog2(num_cores);
  endfunction

  localparam int unsigned SUM_W = DEF_STEP_W + $clog2(DEF_NUM_CORES);

endpackage

// File: rtl/difftest_step_adder_tree.sv
// Combinational sum of all per-core step lanes, zero-extended to OUT_W.
module difftest_step_adder_tree
  import difftest_step_pkg::*;
#(
  parameter int unsigned NUM_CORES = DEF_NUM_CORES,
  parameter int unsigned STEP_W    = DEF_STEP_W,
  parameter int unsigned OUT_W     = SUM_W
) (
  input  logic [NUM_CORES*STEP_W-1:0] in_step,
  output logic [OUT_W-1:0]            sum
);

  // Accumulate every lane; OUT_W is wide enough that this never overflows.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      sum = sum + OUT_W'(in_step[i*STEP_W +: STEP_W]);
    end
  end

endmodule

// File: rtl/difftest_step_scheduler.sv
// Batches per-core commit step counts into step requests for the simulator
// step sink, and freezes on the first nonzero deferred result from the host.
module difftest_step_scheduler
  import difftest_step_pkg::*;
#(
  parameter int unsigned NUM_CORES  = DEF_NUM_CORES,
  parameter int unsigned STEP_W     = DEF_STEP_W,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned BATCH      = 32,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned HIGH_WATER = 60000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CORES*STEP_W-1:0] in_step,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output logic                        out_valid,
  output logic [STEP_W-1:0]           out_step,
  input  logic                        out_ready,
  input  logic [7:0]                  result,
  output logic                        halted,
  output logic [7:0]                  halt_code,
  output logic [ACC_W-1:0]            pending
);

  localparam int unsigned LANE_SUM_W = sum_width(STEP_W, NUM_CORES);
  localparam int unsigned TIMER_W    = $clog2(TIMEOUT + 1);

  localparam logic [ACC_W-1:0]   BATCH_L    = ACC_W'(BATCH);
  localparam logic [ACC_W-1:0]   HWATER_L   = ACC_W'(HIGH_WATER);
  localparam logic [ACC_W-1:0]   STEP_MAX_L = ACC_W'((64'd1 << STEP_W) - 64'd1);
  localparam logic [TIMER_W-1:0] TIMEOUT_L  = TIMER_W'(TIMEOUT - 1);

  logic [LANE_SUM_W-1:0] lane_sum;

  sched_state_e         state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 out_valid_q, out_valid_d;
  logic [STEP_W-1:0]    out_step_q, out_step_d;
  logic                 halted_q, halted_d;
  logic [7:0]           halt_code_q, halt_code_d;
  logic                 in_ready_q, in_ready_d;

  logic                 in_fire;
  logic                 out_fire;
  logic                 halt_now;
  logic [ACC_W-1:0]     add_amt;
  logic [ACC_W-1:0]     sub_amt;
  logic [ACC_W:0]       acc_plus;
  logic [ACC_W-1:0]     acc_next;
  logic [STEP_W-1:0]    capped_step;

  difftest_step_adder_tree #(
    .NUM_CORES (NUM_CORES),
    .STEP_W    (STEP_W),
    .OUT_W     (LANE_SUM_W)
  ) u_adder_tree (
    .in_step (in_step),
    .sum     (lane_sum)
  );

  // Handshakes, accumulator arithmetic and the request size cap.
  always_comb begin
    in_fire     = in_valid & in_ready_q;
    out_fire    = out_valid_q & out_ready;
    add_amt     = in_fire ? ACC_W'(lane_sum) : '0;
    sub_amt     = out_fire ? ACC_W'(out_step_q) : '0;
    acc_plus    = {1'b0, acc_q} + {1'b0, add_amt};
    acc_next    = acc_plus[ACC_W-1:0] - sub_amt;
    halt_now    = halted_q | (result != 8'd0);
    capped_step = (acc_q > STEP_MAX_L) ? '1 : acc_q[STEP_W-1:0];
  end

  // Next-state logic. Outputs are derived from the next state so every
  // output port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_next;
    timer_d     = timer_q;
    out_step_d  = out_step_q;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (halt_now) begin
          state_d = HALT;
        end else if (in_fire && (lane_sum != '0)) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        timer_d = timer_q + TIMER_W'(1);
        if (halt_now) begin
          state_d = HALT;
        end else if ((acc_q >= BATCH_L) || (timer_q == TIMEOUT_L) ||
                     (flush && (acc_next != '0))) begin
          // acc_q is never zero in ACCUM, so the latched size is never zero
          // and never exceeds what out_fire later subtracts from acc.
          state_d    = ISSUE;
          timer_d    = '0;
          out_step_d = capped_step;
        end
      end
      ISSUE: begin
        timer_d = '0;
        if (out_fire) begin
          if (halt_now) begin
            state_d = HALT;
          end else if (acc_next != '0) begin
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: begin
        acc_d   = acc_q;
        timer_d = '0;
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        timer_d = '0;
      end
    endcase

    halted_d    = halt_now;
    halt_code_d = (!halted_q && (result != 8'd0)) ? result : halt_code_q;
    in_ready_d  = !halted_d && (acc_d < HWATER_L);
    out_valid_d = (state_d == ISSUE);
  end

  // All scheduler state, synchronously reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_step_q  <= '0;
      halted_q    <= 1'b0;
      halt_code_q <= 8'd0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      timer_q     <= timer_d;
      out_valid_q <= out_valid_d;
      out_step_q  <= out_step_d;
      halted_q    <= halted_d;
      halt_code_q <= halt_code_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_step  = out_step_q;
  assign halted    = halted_q;
  assign halt_code = halt_code_q;
  assign pending   = acc_q;

  // The accumulator must neither wrap on add nor borrow on subtract.
  acc_no_wrap_a: assert property (@(posedge clock) disable iff (reset)
    (!acc_plus[ACC_W] && (acc_plus >= {1'b0, sub_amt})));

  // A presented request always carries at least one step.
  step_nonzero_a: assert property (@(posedge clock) disable iff (reset)
    (!out_valid_q || (out_step_q != '0)));

endmodule
